// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module : pipe_ctrl_pkg
// Brief  : Opcodes, ALU/writeback encodings and staged control bundles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LOADS  = 7'b0000011;
    localparam logic [6:0] SAVES  = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    // Base ALU op width; wider ALUOP_W values zero-extend this code.
    localparam int ALUOP_BASE_W = 3;

    typedef enum logic [ALUOP_BASE_W-1:0] {
        ALU_ADD   = 3'b000,
        ALU_BR    = 3'b001,
        ALU_R     = 3'b010,
        ALU_I     = 3'b011,
        ALU_PASSB = 3'b100
    } aluop_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wbsel_e;

    typedef struct packed {
        logic   alusrc;
        aluop_e aluop;
        logic   branch;
        logic   jump;
        logic   jalr;
        logic   pcsrc_a;
    } ctrl_ex_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
    } ctrl_mem_t;

    typedef struct packed {
        logic   regwrite;
        wbsel_e wb_sel;
    } ctrl_wb_t;

    localparam ctrl_ex_t  c_ex_zero  = '0;
    localparam ctrl_mem_t c_mem_zero = '0;
    localparam ctrl_wb_t  c_wb_zero  = '0;

endpackage : pipe_ctrl_pkg

`default_nettype wire

// File: rtl/pipe_ctrl_unit_if.sv
// ============================================================================
// Module : pipe_ctrl_unit_if
// Brief  : ID-stage inputs and staged control outputs of the pipeline controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_ctrl_unit_if #(
    parameter int ALUOP_W = 3,
    parameter int REG_AW  = 5
);
    logic               id_valid;
    logic [6:0]         id_opcode;
    logic [REG_AW-1:0]  id_rs1;
    logic [REG_AW-1:0]  id_rs2;
    logic [REG_AW-1:0]  id_rd;
    logic               ex_redirect;

    logic               stall;
    logic               id_illegal;
    logic               ex_alusrc;
    logic [ALUOP_W-1:0] ex_aluop;
    logic               ex_branch;
    logic               ex_jump;
    logic               ex_jalr;
    logic               ex_pcsrc_a;
    logic [REG_AW-1:0]  ex_rd;
    logic               mem_read;
    logic               mem_write;
    logic [REG_AW-1:0]  mem_rd;
    logic               mem_regwrite;
    logic               wb_regwrite;
    logic [1:0]         wb_sel;
    logic [REG_AW-1:0]  wb_rd;

    // Datapath side: presents the ID instruction and consumes staged control.
    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_redirect,
        input  stall, id_illegal,
        input  ex_alusrc, ex_aluop, ex_branch, ex_jump, ex_jalr, ex_pcsrc_a, ex_rd,
        input  mem_read, mem_write, mem_rd, mem_regwrite,
        input  wb_regwrite, wb_sel, wb_rd
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_redirect,
        output stall, id_illegal,
        output ex_alusrc, ex_aluop, ex_branch, ex_jump, ex_jalr, ex_pcsrc_a, ex_rd,
        output mem_read, mem_write, mem_rd, mem_regwrite,
        output wb_regwrite, wb_sel, wb_rd
    );

endinterface : pipe_ctrl_unit_if

`default_nettype wire

// File: rtl/pipe_ctrl_decode.sv
// ============================================================================
// Module : pipe_ctrl_decode
// Brief  : Combinational ID opcode decoder producing EX/MEM/WB control bundles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter bit EN_JUMP  = 1'b1,
    parameter bit EN_UPPER = 1'b1
) (
    input  logic              valid,
    input  logic [6:0]        opcode,
    input  logic [REG_AW-1:0] rd,
    output ctrl_ex_t          ex_ctrl,
    output ctrl_mem_t         mem_ctrl,
    output ctrl_wb_t          wb_ctrl,
    output logic [REG_AW-1:0] rd_out,
    output logic              illegal,
    output logic              uses_rs1,
    output logic              uses_rs2
);

    ctrl_ex_t  w_ex;
    ctrl_mem_t w_mem;
    ctrl_wb_t  w_wb;
    logic      w_legal;
    logic      w_rs1;
    logic      w_rs2;

    always_comb begin
        w_ex    = c_ex_zero;
        w_mem   = c_mem_zero;
        w_wb    = c_wb_zero;
        w_legal = 1'b1;
        w_rs1   = 1'b0;
        w_rs2   = 1'b0;
        case (opcode)
            R_TYPE: begin
                w_ex.aluop     = ALU_R;
                w_wb.regwrite  = 1'b1;
                w_wb.wb_sel    = WB_ALU;
                w_rs1          = 1'b1;
                w_rs2          = 1'b1;
            end
            I_TYPE: begin
                w_ex.alusrc    = 1'b1;
                w_ex.aluop     = ALU_I;
                w_wb.regwrite  = 1'b1;
                w_rs1          = 1'b1;
            end
            LOADS: begin
                w_ex.alusrc    = 1'b1;
                w_ex.aluop     = ALU_ADD;
                w_mem.mem_read = 1'b1;
                w_wb.regwrite  = 1'b1;
                w_wb.wb_sel    = WB_MEM;
                w_rs1          = 1'b1;
            end
            SAVES: begin
                w_ex.alusrc     = 1'b1;
                w_ex.aluop      = ALU_ADD;
                w_mem.mem_write = 1'b1;
                w_rs1           = 1'b1;
                w_rs2           = 1'b1;
            end
            BR: begin
                w_ex.aluop     = ALU_BR;
                w_ex.branch    = 1'b1;
                w_rs1          = 1'b1;
                w_rs2          = 1'b1;
            end
            JAL: begin
                if (EN_JUMP) begin
                    w_ex.jump     = 1'b1;
                    w_ex.pcsrc_a  = 1'b1;
                    w_ex.alusrc   = 1'b1;
                    w_ex.aluop    = ALU_ADD;
                    w_wb.regwrite = 1'b1;
                    w_wb.wb_sel   = WB_PC4;
                end else begin
                    w_legal = 1'b0;
                end
            end
            JALR: begin
                if (EN_JUMP) begin
                    w_ex.jalr     = 1'b1;
                    w_ex.alusrc   = 1'b1;
                    w_ex.aluop    = ALU_ADD;
                    w_wb.regwrite = 1'b1;
                    w_wb.wb_sel   = WB_PC4;
                    w_rs1         = 1'b1;
                end else begin
                    w_legal = 1'b0;
                end
            end
            LUI: begin
                if (EN_UPPER) begin
                    w_ex.alusrc   = 1'b1;
                    w_ex.aluop    = ALU_PASSB;
                    w_wb.regwrite = 1'b1;
                end else begin
                    w_legal = 1'b0;
                end
            end
            AUIPC: begin
                if (EN_UPPER) begin
                    w_ex.pcsrc_a  = 1'b1;
                    w_ex.alusrc   = 1'b1;
                    w_ex.aluop    = ALU_ADD;
                    w_wb.regwrite = 1'b1;
                end else begin
                    w_legal = 1'b0;
                end
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Invalid or unsupported slots collapse to a NOP; writes to x0 are dropped.
    always_comb begin
        ex_ctrl  = c_ex_zero;
        mem_ctrl = c_mem_zero;
        wb_ctrl  = c_wb_zero;
        rd_out   = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        if (valid && w_legal) begin
            ex_ctrl          = w_ex;
            mem_ctrl         = w_mem;
            wb_ctrl          = w_wb;
            wb_ctrl.regwrite = w_wb.regwrite && (rd != '0);
            rd_out           = rd;
            uses_rs1         = w_rs1;
            uses_rs2         = w_rs2;
        end
    end

    assign illegal = valid && !w_legal;

endmodule : pipe_ctrl_decode

`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
// ============================================================================
// Module : pipe_ctrl_unit
// Brief  : ID/EX, EX/MEM, MEM/WB control staging with load-use stall and flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int ALUOP_W  = 3,
    parameter int REG_AW   = 5,
    parameter bit EN_JUMP  = 1'b1,
    parameter bit EN_UPPER = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    pipe_ctrl_unit_if.slave bus
);

    ctrl_ex_t          w_dec_ex;
    ctrl_mem_t         w_dec_mem;
    ctrl_wb_t          w_dec_wb;
    logic [REG_AW-1:0] w_dec_rd;
    logic              w_dec_illegal;
    logic              w_uses_rs1;
    logic              w_uses_rs2;
    logic              w_stall;
    logic              w_bubble;

    ctrl_ex_t          r_idex_ex;
    ctrl_mem_t         r_idex_mem;
    ctrl_wb_t          r_idex_wb;
    logic [REG_AW-1:0] r_idex_rd;

    ctrl_mem_t         r_exmem_mem;
    ctrl_wb_t          r_exmem_wb;
    logic [REG_AW-1:0] r_exmem_rd;

    ctrl_wb_t          r_memwb_wb;
    logic [REG_AW-1:0] r_memwb_rd;

    pipe_ctrl_decode #(
        .REG_AW   (REG_AW),
        .EN_JUMP  (EN_JUMP),
        .EN_UPPER (EN_UPPER)
    ) u_decode (
        .valid    (bus.id_valid),
        .opcode   (bus.id_opcode),
        .rd       (bus.id_rd),
        .ex_ctrl  (w_dec_ex),
        .mem_ctrl (w_dec_mem),
        .wb_ctrl  (w_dec_wb),
        .rd_out   (w_dec_rd),
        .illegal  (w_dec_illegal),
        .uses_rs1 (w_uses_rs1),
        .uses_rs2 (w_uses_rs2)
    );

    // The load sitting in EX cannot forward until MEM, so a dependent ID op waits one cycle.
    assign w_stall = bus.id_valid
                  && r_idex_mem.mem_read
                  && (r_idex_rd != '0)
                  && (((r_idex_rd == bus.id_rs1) && w_uses_rs1)
                   || ((r_idex_rd == bus.id_rs2) && w_uses_rs2));

    assign w_bubble = bus.ex_redirect || w_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idex_ex   <= c_ex_zero;
            r_idex_mem  <= c_mem_zero;
            r_idex_wb   <= c_wb_zero;
            r_idex_rd   <= '0;
            r_exmem_mem <= c_mem_zero;
            r_exmem_wb  <= c_wb_zero;
            r_exmem_rd  <= '0;
            r_memwb_wb  <= c_wb_zero;
            r_memwb_rd  <= '0;
        end else begin
            if (w_bubble) begin
                r_idex_ex  <= c_ex_zero;
                r_idex_mem <= c_mem_zero;
                r_idex_wb  <= c_wb_zero;
                r_idex_rd  <= '0;
            end else begin
                r_idex_ex  <= w_dec_ex;
                r_idex_mem <= w_dec_mem;
                r_idex_wb  <= w_dec_wb;
                r_idex_rd  <= w_dec_rd;
            end
            r_exmem_mem <= r_idex_mem;
            r_exmem_wb  <= r_idex_wb;
            r_exmem_rd  <= r_idex_rd;
            r_memwb_wb  <= r_exmem_wb;
            r_memwb_rd  <= r_exmem_rd;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.id_illegal   = w_dec_illegal;

    assign bus.ex_alusrc    = r_idex_ex.alusrc;
    assign bus.ex_aluop     = ALUOP_W'(r_idex_ex.aluop);
    assign bus.ex_branch    = r_idex_ex.branch;
    assign bus.ex_jump      = r_idex_ex.jump;
    assign bus.ex_jalr      = r_idex_ex.jalr;
    assign bus.ex_pcsrc_a   = r_idex_ex.pcsrc_a;
    assign bus.ex_rd        = r_idex_rd;

    assign bus.mem_read     = r_exmem_mem.mem_read;
    assign bus.mem_write    = r_exmem_mem.mem_write;
    assign bus.mem_rd       = r_exmem_rd;
    assign bus.mem_regwrite = r_exmem_wb.regwrite;

    assign bus.wb_regwrite  = r_memwb_wb.regwrite;
    assign bus.wb_sel       = r_memwb_wb.wb_sel;
    assign bus.wb_rd        = r_memwb_rd;

endmodule : pipe_ctrl_unit

`default_nettype wire

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Parametrised successor to the single-cycle opcode decoder.
- Decodes the 7-bit opcode in ID, including optional JAL/JALR/LUI/AUIPC support.
- Carries control bundles through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards (stall) and applies branch/jump flushes, so the datapath pipeline sees correctly staged, bubble-safe control.

Parameters:
- ALUOP_W, 3, width of ALU operation code; must be >= 3.
- REG_AW, 5, register-index width.
- EN_JUMP, 1, 1 = decode JAL (1101111) and JALR (1100111); 0 = treat them as illegal.
- EN_UPPER, 1, 1 = decode LUI (0110111) and AUIPC (0010111); 0 = treat them as illegal.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  7  instruction[6:0].
- id_rs1  in  REG_AW  source register 1.
- id_rs2  in  REG_AW  source register 2.
- id_rd  in  REG_AW  destination register.
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
- stall  out  1  hold PC and IF/ID (combinational).
- id_illegal  out  1  valid opcode not supported (combinational).
- ex_alusrc  out  1  EX-stage ALU operand B select; 1 = immediate.
- ex_aluop  out  ALUOP_W  EX-stage ALU operation.
- ex_branch  out  1  EX-stage branch.
- ex_jump  out  1  EX-stage JAL.
- ex_jalr  out  1  EX-stage JALR.
- ex_pcsrc_a  out  1  EX-stage operand A select; 1 = PC (AUIPC/JAL/JALR).
- ex_rd  out  REG_AW  EX-stage destination.
- mem_read  out  1  MEM-stage read.
- mem_write  out  1  MEM-stage write.
- mem_rd  out  REG_AW  MEM-stage destination.
- mem_regwrite  out  1  MEM-stage writeback pending (for forwarding).
- wb_regwrite  out  1  WB-stage register write.
- wb_sel  out  2  WB-stage result select: 00 ALU, 01 memory, 10 PC+4.
- wb_rd  out  REG_AW  WB-stage destination.

Behaviour:
- Decode (combinational, ID):
  - R 0110011: aluop=010, regwrite, wb_sel=00.
  - I 0010011: alusrc, aluop=011, regwrite.
  - LOAD 0000011: alusrc, aluop=000, mem_read, regwrite, wb_sel=01.
  - STORE 0100011: alusrc, aluop=000, mem_write.
  - BRANCH 1100011: aluop=001, branch.
  - JAL: jump, regwrite, wb_sel=10, pcsrc_a, alusrc, aluop=000.
  - JALR: jalr, regwrite, wb_sel=10, alusrc, aluop=000.
  - LUI: alusrc, aluop=100 (pass B), regwrite.
  - AUIPC: pcsrc_a, alusrc, aluop=000, regwrite.
  - Upper aluop bits beyond bit 2 are zero.
- Any other opcode, or a disabled class: id_illegal=1 when id_valid, and the decoded bundle is all-zero (NOP).
- rd==0 forces regwrite=0 in the decoded bundle.
- id_valid=0 produces the all-zero bundle.
- Rs usage: rs1 is used by R, I, LOAD, STORE, BRANCH, JALR. rs2 is used by R, STORE, BRANCH.
- Load-use:
  - stall = ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs1 & uses_rs1) | (ex_rd==id_rs2 & uses_rs2)) & id_valid.
  - ex_mem_read is the internal EX copy of mem_read.
- Stage update, every rising clk, in priority order:
  1. !rst_n: all stage registers zero, so every output control bit is 0, every rd is 0, and wb_sel=00.
  2. ex_redirect: ID/EX loads the zero bundle (flush). Flush overrides stall. EX/MEM still advances normally, because the redirecting instruction itself proceeds.
  3. stall: ID/EX loads the zero bundle (bubble). EX/MEM and MEM/WB advance.
  4. Otherwise: ID/EX gets the decode, EX/MEM gets ID/EX, MEM/WB gets EX/MEM.
- Latency:
  - ID decode appears on the ex_* outputs 1 cycle later, on the mem_* outputs 2 cycles later, and on the wb_* outputs 3 cycles later.
  - stall and id_illegal have zero latency.
- Flushing the IF/ID register on ex_redirect is the fetch unit's responsibility. This block only zeroes ID/EX.
- Reset deasserted mid-stream: the first cycle after reset, the pipeline is all bubbles.
- stall is never asserted on two consecutive cycles for the same instruction, because the bubble clears the EX load.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the opcode localparams (R_TYPE, I_TYPE, LOADS, SAVES, BR, JAL, JALR, LUI, AUIPC);
  - the ALUOp encodings;
  - the wb_sel encodings;
  - packed struct typedefs ctrl_ex_t, ctrl_mem_t and ctrl_wb_t, plus a zero constant for each.
- One sub-module, pipe_ctrl_decode, is combinational (opcode, valid, rd -> bundle, illegal, uses_rs1/rs2). It is instantiated once; the stage registers and hazard logic live in the top.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random inputs -> all outputs 0, stall=0; a LOAD issued the cycle after release appears on ex_* one cycle later.
- Stream R(rd=5), I, LOAD(rd=6), STORE -> ex_aluop sequence 010, 011, 000, 000; mem_read pulses exactly 2 cycles after the LOAD; wb_sel=01 with wb_rd=6 3 cycles after the LOAD.
- Load-use: LOAD rd=7, then R with rs2=7 -> stall=1 for exactly one cycle; ex_* all zero that cycle; R appears in EX the next cycle; stall=0.
- LOAD rd=0, then R with rs1=0 -> no stall; the LOAD's wb_regwrite=0.
- Stall and flush together: ex_redirect=1 while stall=1 -> ID/EX zero next cycle; the following decode proceeds without an extra bubble.
- Parameters: EN_JUMP=0 with opcode 1101111 -> id_illegal=1 and a zero bundle; EN_JUMP=1 -> ex_jump=1, then wb_sel=10 three cycles after issue; LUI -> aluop=100.
